// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg -- shared types and helpers for serial_subtractor_mux.
//   state_t : FSM encoding (ST_IDLE, ST_RUN, ST_DONE)
//   cnt_w() : bit-counter width for a given operand WIDTH
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH-1; keep at least one bit.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor_mux.sv
// mux_2x1            -- 1-bit 2:1 mux, y = sel ? d1 : d0.
// full_subtractor_mux -- 1-bit full subtractor (a - b - bin) built from two
//   mux_2x1 cells selected by the minuend bit a.
//   in : a, b, bin   out : d (difference), bout (borrow out)
module mux_2x1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module full_subtractor_mux (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic x;
  assign x = b ^ bin;

  // a=0: d = b^bin,    bout = b|bin
  // a=1: d = ~(b^bin), bout = b&bin
  mux_2x1 u_mux_d    (.d0(x),       .d1(~x),      .sel(a), .y(d));
  mux_2x1 u_mux_bout (.d0(b | bin), .d1(b & bin), .sel(a), .y(bout));
endmodule

// File: rtl/serial_subtractor_mux.sv
// serial_subtractor_mux -- bit-serial WIDTH-bit unsigned subtractor,
// diff = a - b (mod 2^WIDTH), one bit per clock LSB first.
//   clk, rst (sync, active-high)
//   start, a, b           : request; a/b captured when accepted (IDLE/DONE)
//   busy                  : high for the WIDTH RUN cycles
//   done                  : one-cycle pulse, diff/borrow_out valid
//   diff, borrow_out      : result, held until the next completion
//   ovf                   : signed overflow, only with SUB_SIGNED_OVF_EN
// Build option: `define SUB_SIGNED_OVF_EN adds the ovf port and register.
module serial_subtractor_mux
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             accept, last;
  logic             cell_d, cell_bout;

  full_subtractor_mux u_cell (
    .a   (sa[0]),
    .b   (sb[0]),
    .bin (bin),
    .d   (cell_d),
    .bout(cell_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        accept  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: if (cnt == CW'(WIDTH - 1)) begin
        last    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      bin        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf        <= 1'b0;
`endif
    end else if (accept) begin
      sa   <= a;
      sb   <= b;
      bin  <= 1'b0;
      cnt  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (state_q == ST_RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      bin <= cell_bout;
      cnt <= cnt + 1'b1;
      // Result enters from the MSB side; after WIDTH shifts bit 0 is the LSB.
      res <= {cell_d, res[WIDTH-1:1]};
      if (last) begin
        diff       <= {cell_d, res[WIDTH-1:1]};
        borrow_out <= cell_bout;
        done       <= 1'b1;
        busy       <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
        // On the last step sa[0]/sb[0] are the operand MSBs, cell_d the diff MSB.
        ovf        <= (sa[0] ^ sb[0]) & (cell_d ^ sa[0]);
`endif
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_subtractor_mux.sv
module tb_serial_subtractor_mux;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, diff;
  logic         busy, done, borrow_out;
`ifdef SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference results, from plain arithmetic.
  logic [W-1:0] m_diff;
  logic         m_bor, m_ovf;

  always #5 clk = ~clk;

  serial_subtractor_mux #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, sd;
    m_diff = W'(int'(x) - int'(y));
    m_bor  = (x < y);
    sx = (int'(x) >= (1 << (W-1))) ? int'(x) - (1 << W) : int'(x);
    sy = (int'(y) >= (1 << (W-1))) ? int'(y) - (1 << W) : int'(y);
    sd = sx - sy;
    m_ovf = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_diff"}, diff, m_diff);
    chk({tag, "_bor"}, borrow_out, m_bor);
`ifdef SUB_SIGNED_OVF_EN
    chk({tag, "_ovf"}, ovf, m_ovf);
`endif
  endtask

  // One operation; poke re-pulses start mid-run with other operands.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    logic [W-1:0] held;
    held = m_diff;
    @(negedge clk); start = 1'b1; a = x; b = y;
    @(negedge clk); start = 1'b0; a = W'($urandom); b = W'($urandom);
    chk("acc_busy", busy, 1);
    chk("acc_done", done, 0);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (k < W) begin
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        chk("run_hold", diff, held);
        if (poke && k == 2) begin start = 1'b1; a = W'($urandom); b = W'($urandom); end
        if (poke && k == 3) start = 1'b0;
      end else begin
        model(x, y);
        chk_result("op");
      end
    end
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    logic [W-1:0] xs [3];
    logic [W-1:0] ys [3];

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    m_diff = '0; m_bor = 1'b0; m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bor", borrow_out, 0);
`ifdef SUB_SIGNED_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;

    op(8'd200, 8'd55, 1'b0);
    op(8'd55, 8'd200, 1'b0);
    op(8'd0, 8'd1, 1'b0);
    op(8'hA5, 8'hA5, 1'b0);
    op(8'h80, 8'h01, 1'b0);
    op(8'h10, 8'h01, 1'b0);
    op(8'h7F, 8'hFF, 1'b0);
    op(8'd77, 8'd13, 1'b1);   // ignored re-start mid-run
    for (int i = 0; i < 12; i++) op(W'($urandom), W'($urandom), i[0]);

    // start held high: three back-to-back operations W+1 cycles apart
    for (int i = 0; i < 3; i++) begin xs[i] = W'($urandom); ys[i] = W'($urandom); end
    @(negedge clk); start = 1'b1; a = xs[0]; b = ys[0];
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k <= W; k++) begin
        @(negedge clk);
        if (k < W) begin
          chk("b2b_busy", busy, 1);
          chk("b2b_done", done, 0);
          if (k == 1) begin a = W'($urandom); b = W'($urandom); end
        end else begin
          model(xs[i], ys[i]);
          chk_result("b2b");
          if (i < 2) begin a = xs[i+1]; b = ys[i+1]; end
          else start = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("b2b_end_done", done, 0);
    chk("b2b_end_busy", busy, 0);

    // reset mid-operation
    op(8'd200, 8'd55, 1'b0);
    @(negedge clk); start = 1'b1; a = 8'h3C; b = 8'hC3;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bor", borrow_out, 0);
`ifdef SUB_SIGNED_OVF_EN
    chk("mid_rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    m_diff = '0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      chk("no_done", done, 0);
    end
    op(8'd9, 8'd250, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
